// File: rtl/pipeline_sequencer_if.sv
// Handshake/bus bundle between fetch/hazard control and the stage register chain.
// Parameters must match the attached pipeline_sequencer instance.
interface pipeline_sequencer_if #(
  parameter int NUM_STAGES = 4,
  parameter int PAYLOAD_W  = 64
);
  localparam int FLUSH_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                          enable;
  logic                          in_valid;
  logic [PAYLOAD_W-1:0]          in_payload;
  logic                          in_ready;
  logic [NUM_STAGES-1:0]         stall_req;
  logic                          flush_req;
  logic [FLUSH_W-1:0]            flush_stage;
  logic [NUM_STAGES-1:0]         stage_valid;
  logic [NUM_STAGES*PAYLOAD_W-1:0] stage_payload;

  modport master (
    output enable, in_valid, in_payload,
    output stall_req, flush_req, flush_stage,
    input  in_ready, stage_valid, stage_payload
  );

  modport slave (
    input  enable, in_valid, in_payload,
    input  stall_req, flush_req, flush_stage,
    output in_ready, stage_valid, stage_payload
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// In-order stage register chain with valid bits, stall/bubble and branch flush.
// PIPE_PERF_CNT_EN adds saturating stall_cycles / flush_kills counters.
module pipeline_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int PAYLOAD_W  = 64
) (
  input  logic clk,
  input  logic rst,
  pipeline_sequencer_if.slave bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_kills
`endif
);

  localparam int FW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [FW-1:0] LAST = FW'(NUM_STAGES - 1);

  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [NUM_STAGES-1:0][PAYLOAD_W-1:0] pay_q, pay_d;
  logic [NUM_STAGES-1:0] es, hold;
  logic [FW-1:0] fcl;

  // hold[i]: some stage at or older than i is stalled
  always_comb begin
    es = bus.stall_req & valid_q;
    hold = '0;
    hold[NUM_STAGES-1] = es[NUM_STAGES-1];
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      hold[i] = hold[i+1] | es[i];
    end
    fcl = (bus.flush_stage >= LAST) ? LAST : bus.flush_stage;
  end

  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    if (bus.enable) begin
      if (bus.flush_req) begin
        valid_d[0] = 1'b0;
        pay_d[0]   = '0;
      end else if (!hold[0]) begin
        valid_d[0] = bus.in_valid;
        pay_d[0]   = bus.in_valid ? bus.in_payload : '0;
      end
      for (int i = 1; i < NUM_STAGES; i++) begin
        if (bus.flush_req) begin
          if (FW'(i) <= fcl) begin
            valid_d[i] = 1'b0;
            pay_d[i]   = '0;
          end else begin
            valid_d[i] = valid_q[i-1];
            pay_d[i]   = pay_q[i-1];
          end
        end else if (!hold[i]) begin
          if (hold[i-1]) begin
            valid_d[i] = 1'b0;
            pay_d[i]   = '0;
          end else begin
            valid_d[i] = valid_q[i-1];
            pay_d[i]   = pay_q[i-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
    end
  end

  assign bus.in_ready      = bus.enable & (~hold[0] | bus.flush_req);
  assign bus.stage_valid   = valid_q;
  assign bus.stage_payload = pay_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, kill_cnt_q;
  logic [31:0] kills;
  logic [32:0] kill_sum;
  logic        stall_inc;

  // valid stages strictly younger than the branch are the ones killed
  always_comb begin
    kills = '0;
    for (int j = 0; j < NUM_STAGES - 1; j++) begin
      if (FW'(j) < fcl) kills = kills + 32'(valid_q[j]);
    end
    kill_sum  = {1'b0, kill_cnt_q} + {1'b0, kills};
    stall_inc = bus.enable & hold[0] & ~bus.flush_req;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      if (stall_inc && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (bus.enable && bus.flush_req) begin
        kill_cnt_q <= kill_sum[32] ? '1 : kill_sum[31:0];
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_kills  = kill_cnt_q;
`endif

endmodule
